// File: rtl/float_combine_pipe.sv
// rtl/float_combine_pipe.sv - three-stage normalise/round/pack of {sign, exp, extended mantissa} to a float word
// FLOAT_COMBINE_PIPE_ROUND_EN selects round-to-nearest-even; truncation otherwise.
module float_combine_pipe #(
   parameter int EXP_WIDTH   = 8,
   parameter int MAN_WIDTH   = 23,
   parameter int EXTRA_WIDTH = 3
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_sign,
   input  logic [EXP_WIDTH+1:0]               in_exp,
   input  logic [MAN_WIDTH+EXTRA_WIDTH+1:0]   in_man,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [EXP_WIDTH+MAN_WIDTH:0]       out_res,
   output logic [2:0]                         out_flags
);
   localparam int EW  = EXP_WIDTH;
   localparam int MW  = MAN_WIDTH;
   localparam int XW  = EXTRA_WIDTH;
   localparam int NW  = MW + XW + 2;
   localparam int LZW = $clog2(NW + 1);
   localparam int E1W = EW + 3;
   localparam int PW  = EW + 2;
   localparam int RW  = EW + MW + 1;
   localparam logic [PW:0] EXP_MAX = (PW+1)'((1 << EW) - 1);

   logic             v1_q, v1_d, sign1_q, sign1_d, zero1_q, zero1_d;
   logic [LZW-1:0]   lz1_q, lz1_d;
   logic [E1W-1:0]   e1_q, e1_d;
   logic [NW-1:0]    man1_q, man1_d;

   logic             v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d, sub2_q, sub2_d;
   logic [PW-1:0]    exp2_q, exp2_d;
   logic [MW:0]      mant2_q, mant2_d;
   logic             grd2_q, grd2_d, rnd2_q, rnd2_d, stk2_q, stk2_d;

   logic             v3_q, v3_d;
   logic [RW-1:0]    res3_q, res3_d;
   logic [2:0]       flags3_q, flags3_d;

   logic             load1, load2, load3;
   logic [LZW-1:0]   lz;
   logic             found;
   logic [NW-1:0]    norm, shifted;
   logic             e1_le0, lost;
   logic [E1W-1:0]   sh_full;
   logic [LZW-1:0]   sh;
   logic             inc, carry, inexact, ovf;
   logic [MW+1:0]    sum;
   logic [MW-1:0]    man_out;
   logic [PW:0]      exp_res;

   // A stage advances when empty or when its successor advances.
   always_comb begin
      load3    = !v3_q || out_ready;
      load2    = !v2_q || load3;
      load1    = !v1_q || load2;
      in_ready = load1;
   end

   always_comb begin
      lz    = LZW'(NW);
      found = 1'b0;
      for (int i = NW - 1; i >= 0; i--) begin
         if (!found && in_man[i]) begin
            lz    = LZW'(NW - 1 - i);
            found = 1'b1;
         end
      end
      v1_d    = load1 ? in_valid : v1_q;
      sign1_d = sign1_q;
      zero1_d = zero1_q;
      lz1_d   = lz1_q;
      e1_d    = e1_q;
      man1_d  = man1_q;
      if (load1 && in_valid) begin
         sign1_d = in_sign;
         zero1_d = (in_man == '0);
         lz1_d   = lz;
         man1_d  = in_man;
         e1_d    = {in_exp[PW-1], in_exp} + E1W'(1) - E1W'(lz);
      end
   end

   // Denormalising shift: everything pushed below the kept bits folds into sticky.
   always_comb begin
      norm    = man1_q << lz1_q;
      e1_le0  = e1_q[E1W-1] || (e1_q == '0);
      sh_full = E1W'(1) - e1_q;
      if (!e1_le0)
         sh = '0;
      else if (sh_full > E1W'(NW))
         sh = LZW'(NW);
      else
         sh = sh_full[LZW-1:0];
      shifted = norm >> sh;
      lost    = |(norm & ~({NW{1'b1}} << sh));

      v2_d    = load2 ? v1_q : v2_q;
      sign2_d = sign2_q;
      zero2_d = zero2_q;
      sub2_d  = sub2_q;
      exp2_d  = exp2_q;
      mant2_d = mant2_q;
      grd2_d  = grd2_q;
      rnd2_d  = rnd2_q;
      stk2_d  = stk2_q;
      if (load2 && v1_q) begin
         sign2_d = sign1_q;
         zero2_d = zero1_q;
         sub2_d  = e1_le0;
         exp2_d  = e1_le0 ? '0 : e1_q[PW-1:0];
         mant2_d = shifted[NW-1 -: MW+1];
         grd2_d  = shifted[XW];
         rnd2_d  = shifted[XW-1];
         stk2_d  = (|shifted[XW-2:0]) | lost;
      end
   end

   always_comb begin
`ifdef FLOAT_COMBINE_PIPE_ROUND_EN
      inc = grd2_q & (rnd2_q | stk2_q | mant2_q[0]);
`else
      inc = 1'b0;
`endif
      sum     = {1'b0, mant2_q} + (MW+2)'(inc);
      // A subnormal that rounds into the hidden-bit position becomes exponent 1.
      carry   = sub2_q ? sum[MW] : sum[MW+1];
      man_out = (!sub2_q && sum[MW+1]) ? sum[MW:1] : sum[MW-1:0];
      exp_res = {1'b0, exp2_q} + (PW+1)'(carry);
      inexact = grd2_q | rnd2_q | stk2_q;
      ovf     = (exp_res >= EXP_MAX);

      v3_d     = load3 ? v2_q : v3_q;
      res3_d   = res3_q;
      flags3_d = flags3_q;
      if (load3 && v2_q) begin
         if (zero2_q) begin
            res3_d   = {sign2_q, {(RW-1){1'b0}}};
            flags3_d = 3'b000;
         end else if (ovf) begin
            res3_d   = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
            flags3_d = 3'b101;
         end else begin
            res3_d   = {sign2_q, exp_res[EW-1:0], man_out};
            flags3_d = {1'b0, sub2_q & inexact, inexact};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         sign1_q  <= 1'b0;
         zero1_q  <= 1'b0;
         lz1_q    <= '0;
         e1_q     <= '0;
         man1_q   <= '0;
         v2_q     <= 1'b0;
         sign2_q  <= 1'b0;
         zero2_q  <= 1'b0;
         sub2_q   <= 1'b0;
         exp2_q   <= '0;
         mant2_q  <= '0;
         grd2_q   <= 1'b0;
         rnd2_q   <= 1'b0;
         stk2_q   <= 1'b0;
         v3_q     <= 1'b0;
         res3_q   <= '0;
         flags3_q <= '0;
      end else begin
         v1_q     <= v1_d;
         sign1_q  <= sign1_d;
         zero1_q  <= zero1_d;
         lz1_q    <= lz1_d;
         e1_q     <= e1_d;
         man1_q   <= man1_d;
         v2_q     <= v2_d;
         sign2_q  <= sign2_d;
         zero2_q  <= zero2_d;
         sub2_q   <= sub2_d;
         exp2_q   <= exp2_d;
         mant2_q  <= mant2_d;
         grd2_q   <= grd2_d;
         rnd2_q   <= rnd2_d;
         stk2_q   <= stk2_d;
         v3_q     <= v3_d;
         res3_q   <= res3_d;
         flags3_q <= flags3_d;
      end
   end

   assign out_valid = v3_q;
   assign out_res   = res3_q;
   assign out_flags = flags3_q;
endmodule

// File: tb/tb_float_combine_pipe.sv
// tb/tb_float_combine_pipe.sv - directed-vector bench for float_combine_pipe
module tb_float_combine_pipe;
   localparam int EW = 8;
   localparam int MW = 23;
   localparam int XW = 3;
   localparam int NW = MW + XW + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_sign = 1'b0;
   logic [EW+1:0] in_exp = '0;
   logic [NW-1:0] in_man = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_res;
   logic [2:0]    out_flags;

   int total = 0;
   int bad = 0;

   float_combine_pipe #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .EXTRA_WIDTH(XW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Presents an item (call just after a posedge) and returns just after the accepting edge.
   task automatic send(input logic s, input logic [EW+1:0] e, input logic [NW-1:0] m,
                       output logic blocked);
      logic acc;
      int guard;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_man   = m;
      blocked  = 1'b0;
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 60) begin
         @(negedge clk);
         #4;
         acc = in_ready;
         if (!acc) blocked = 1'b1;
         @(posedge clk);
         guard++;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_one(input string tag, input logic s, input logic [EW+1:0] e,
                          input logic [NW-1:0] m, input logic [31:0] want_res,
                          input logic [2:0] want_flags, input bit chk_lat);
      logic blk;
      int cyc;
      send(s, e, m, blk);
      #1 in_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      if (!out_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
      if (chk_lat) check({tag, "_latency"}, cyc, 32'd3);
      check({tag, "_res"}, out_res, want_res);
      check({tag, "_flags"}, {29'd0, out_flags}, {29'd0, want_flags});
      @(posedge clk);
      #1;
   endtask

   logic [31:0] tie_odd, rnd_up, sub_carry;
   logic [2:0]  sub_carry_flags;
   logic [31:0] bp_exp [6];
   int          first_block;
   int          bp_got;
   int          seen;
   logic [31:0] snap_res;
   logic [2:0]  snap_flags;
   logic        blk;

   initial begin
`ifdef FLOAT_COMBINE_PIPE_ROUND_EN
      tie_odd   = 32'h3F80_0002;
      rnd_up    = 32'h3F80_0001;
      sub_carry = 32'h0080_0000;
`else
      tie_odd   = 32'h3F80_0001;
      rnd_up    = 32'h3F80_0000;
      sub_carry = 32'h007F_FFFF;
`endif
      sub_carry_flags = 3'b011;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_res", out_res, 32'd0);
      check("rst_out_flags", {29'd0, out_flags}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      run_one("one",      1'b0, 10'd127, 28'h400_0000, 32'h3F80_0000, 3'b000, 1'b1);
      run_one("two",      1'b0, 10'd127, 28'h800_0000, 32'h4000_0000, 3'b000, 1'b1);
      run_one("tie_even", 1'b0, 10'd127, 28'h400_0004, 32'h3F80_0000, 3'b001, 1'b0);
      run_one("tie_odd",  1'b0, 10'd127, 28'h400_000C, tie_odd,       3'b001, 1'b0);
      run_one("rnd_up",   1'b0, 10'd127, 28'h400_0006, rnd_up,        3'b001, 1'b0);
      run_one("neg_1p5",  1'b1, 10'd127, 28'h600_0000, 32'hBFC0_0000, 3'b000, 1'b0);
      run_one("lz7",      1'b0, 10'd130, 28'h010_0000, 32'h3E00_0000, 3'b000, 1'b0);
      run_one("ovf_exp",  1'b0, 10'd255, 28'h400_0000, 32'h7F80_0000, 3'b101, 1'b0);
      run_one("ovf_ones", 1'b0, 10'd254, 28'hFFF_FFFF, 32'h7F80_0000, 3'b101, 1'b0);
      run_one("subn",     1'b0, 10'd0,   28'h400_0000, 32'h0040_0000, 3'b000, 1'b0);
      run_one("subn_rnd", 1'b0, 10'd0,   28'h7FF_FFFF, sub_carry,     sub_carry_flags, 1'b0);
      run_one("uflow",    1'b0, 10'h3E2, 28'h400_0000, 32'h0000_0000, 3'b011, 1'b0);
      run_one("neg_zero", 1'b1, 10'd77,  28'h000_0000, 32'h8000_0000, 3'b000, 1'b0);

      // Backpressure: six items streamed while the sink stalls for five cycles.
      for (int i = 0; i < 6; i++) bp_exp[i] = (32'd127 + 32'(i)) << 23;
      out_ready   = 1'b0;
      first_block = -1;
      bp_got      = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(1'b0, 10'(127 + i), 28'h400_0000, blk);
               if (blk && first_block < 0) first_block = i;
               #1;
            end
            in_valid = 1'b0;
         end
         begin
            int stall_cnt;
            int cyc;
            stall_cnt = 0;
            cyc = 0;
            while (bp_got < 6 && cyc < 200) begin
               @(negedge clk);
               if (out_valid && !out_ready) begin
                  if (stall_cnt == 0) begin
                     snap_res   = out_res;
                     snap_flags = out_flags;
                  end else begin
                     check("bp_hold_res", out_res, snap_res);
                     check("bp_hold_flags", {29'd0, out_flags}, {29'd0, snap_flags});
                  end
                  stall_cnt++;
                  if (stall_cnt == 5) out_ready = 1'b1;
               end
               if (out_valid && out_ready) begin
                  check($sformatf("bp_item%0d", bp_got), out_res, bp_exp[bp_got]);
                  bp_got++;
               end
               cyc++;
            end
         end
      join
      check("bp_count", bp_got, 32'd6);
      check("bp_block_at", first_block, 32'd3);
      @(posedge clk);
      #1;

      // Reset with three items in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 10'(100 + i), 28'h400_0000, blk);
         #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_res", out_res, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_stale_item", seen, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
